// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller that time-multiplexes NUM_DIGITS common-anode digits through one shared 7-segment decoder.
// Define SEVENSEG_BLANK_EN to insert an all-dark BLANK_CYCLES gap after every digit's dwell.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [3*NUM_DIGITS-1:0] load_vals,
    output logic                    load_ready,
    output logic [2:0]              dec_val,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic [1:0]              dbg_state_o
);

    localparam int IW = $clog2(NUM_DIGITS);
`ifdef SEVENSEG_BLANK_EN
    localparam int PCOUNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
`else
    localparam int PCOUNT = DWELL_CYCLES;
`endif
    localparam int PW = $clog2(PCOUNT);

    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
`ifdef SEVENSEG_BLANK_EN
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
`endif
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Handshake: a frame transfers on the rising clk edge where load_valid and
    // load_ready are both 1; load_ready is 1 exactly when the pending buffer is empty.

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [3*NUM_DIGITS-1:0] active_q, active_d;
    logic [3*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [2:0]              dec_val_q, dec_val_d;
    logic                    frame_done_q, frame_done_d;

    logic advance;
    logic wrap;
    logic commit;
    logic capture;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        presc_d      = presc_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        wrap         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                presc_d = '0;
                if (en) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == DWELL_LAST) begin
`ifdef SEVENSEG_BLANK_EN
                    state_d = ST_BLANK;
                    presc_d = '0;
`else
                    advance = 1'b1;
`endif
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
`ifdef SEVENSEG_BLANK_EN
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    advance = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                presc_d = '0;
            end
        endcase

        // Step to the next digit; the wrap back to digit 0 marks the frame boundary.
        if (advance) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        frame_done_d = wrap;
    end

    // Commit happens before capture: a full buffer is committed, an empty one may be filled.
    always_comb begin
        commit       = pend_full_q && (wrap || (state_q == ST_IDLE));
        capture      = load_valid && !pend_full_q;
        active_d     = commit ? pend_q : active_q;
        pend_d       = capture ? load_vals : pend_q;
        pend_full_d  = capture || (pend_full_q && !commit);
        load_ready_d = !pend_full_d;
    end

    // Outputs are derived from next-state values so they line up with the registered state.
    always_comb begin
        dig_sel_d = '0;
        dec_val_d = dec_val_q;
        if (state_d == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == idx_d) begin
                    dig_sel_d[i] = 1'b1;
                    dec_val_d    = active_d[3*i +: 3];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            presc_q      <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            dig_sel_q    <= '0;
            dec_val_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            presc_q      <= presc_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            dig_sel_q    <= dig_sel_d;
            dec_val_q    <= dec_val_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign dig_sel     = dig_sel_q;
    assign dec_val     = dec_val_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dig_sel_q));
    a_params: assert property (@(posedge clk)
        (NUM_DIGITS >= 2) && (NUM_DIGITS <= 8) && (DWELL_CYCLES >= 2) && (BLANK_CYCLES >= 1));

endmodule
